// File: rtl/uart_tx_sched.sv
// Two-channel sample scheduler feeding a byte-style uart_tx word interface.
// Latency: a buffered sample starts its frame one cycle after capture; words follow tx_rdy handshakes.
// Backpressure: per-channel 1-deep buffer; sN_ready drops while the buffer holds an unsent sample.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   en                  permit new frames (a running frame always completes)
//   s0_* / s1_*         valid/ready sample inputs, 2*N_data bits each
//   tx_rdy              uart_tx idle indication (combinationally drops on tx_wreq)
//   tx_wreq, tx_wdata   registered word write request and word to uart_tx
//   busy                scheduler is inside a frame
//   seq                 3-bit frame sequence counter, carried in each header
module uart_tx_sched #(
    parameter int         N_data = 6,
    parameter logic [1:0] HDR    = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  s0_valid,
    input  logic [2*N_data-1:0]   s0_data,
    output logic                  s0_ready,
    input  logic                  s1_valid,
    input  logic [2*N_data-1:0]   s1_data,
    output logic                  s1_ready,
    input  logic                  tx_rdy,
    output logic                  tx_wreq,
    output logic [N_data-1:0]     tx_wdata,
    output logic                  busy,
    output logic [2:0]            seq
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GUARD = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [2:0]            seq_q, seq_d;
    logic                  ptr_q, ptr_d;      // last channel served
    logic [N_data-1:0]     wdata_q, wdata_d;
    logic                  wreq_q, wreq_d;
    logic [2*N_data-1:0]   shift_q, shift_d;  // remaining sample words, MSB word first
    logic                  full0_q, full0_d;
    logic                  full1_q, full1_d;
    logic [2*N_data-1:0]   buf0_q, buf0_d;
    logic [2*N_data-1:0]   buf1_q, buf1_d;

    logic                  sel;
    logic                  clr0, clr1;
    logic                  take0, take1;

    // Header word: marker in the top two bits, then seq, then channel id.
    function automatic logic [N_data-1:0] make_hdr(input logic [2:0] s, input logic ch);
        logic [N_data-1:0] h;
        h                      = '0;
        h[N_data-1:N_data-2]   = HDR;
        h[3:1]                 = s;
        h[0]                   = ch;
        return h;
    endfunction

    // Ready is forced low during reset so nothing is captured into a buffer being cleared.
    assign s0_ready = ~full0_q & ~rst;
    assign s1_ready = ~full1_q & ~rst;
    assign take0    = s0_valid & s0_ready;
    assign take1    = s1_valid & s1_ready;

    assign tx_wreq  = wreq_q;
    assign tx_wdata = wdata_q;
    assign busy     = (state_q != ST_IDLE);
    assign seq      = seq_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        shift_d = shift_q;
        sel     = 1'b0;
        clr0    = 1'b0;
        clr1    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && (full0_q || full1_q)) begin
                    // Tie goes to the channel not served last; otherwise whoever is full.
                    sel     = (full0_q && full1_q) ? ~ptr_q : full1_q;
                    shift_d = sel ? buf1_q : buf0_q;
                    clr0    = ~sel;
                    clr1    = sel;
                    ptr_d   = sel;
                    wdata_d = make_hdr(seq_q, sel);
                    idx_d   = 2'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_rdy) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                // tx_rdy is deliberately ignored here: uart_tx needs a cycle to show busy.
                if (idx_q != 2'd2) begin
                    idx_d   = idx_q + 2'd1;
                    wdata_d = shift_q[2*N_data-1:N_data];
                    shift_d = {shift_q[N_data-1:0], {N_data{1'b0}}};
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tx_rdy) begin
                    seq_d   = seq_q + 3'd1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered write request: asserted exactly while the state register holds ISSUE,
    // so it never depends combinationally on tx_rdy.
    assign wreq_d = (state_d == ST_ISSUE);

    // A buffer is cleared only while full, when its ready is low, so clear and capture never collide.
    always_comb begin
        full0_d = full0_q;
        full1_d = full1_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        if (clr0) begin
            full0_d = 1'b0;
        end else if (take0) begin
            full0_d = 1'b1;
            buf0_d  = s0_data;
        end
        if (clr1) begin
            full1_d = 1'b0;
        end else if (take1) begin
            full1_d = 1'b1;
            buf1_d  = s1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            seq_q   <= 3'd0;
            ptr_q   <= 1'b1;
            wdata_q <= '0;
            wreq_q  <= 1'b0;
            shift_q <= '0;
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            wreq_q  <= wreq_d;
            shift_q <= shift_d;
            full0_q <= full0_d;
            full1_q <= full1_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        s0_valid = 1'b0;
    logic [11:0] s0_data = '0;
    logic        s0_ready;
    logic        s1_valid = 1'b0;
    logic [11:0] s1_data = '0;
    logic        s1_ready;
    logic        tx_rdy;
    logic        tx_wreq;
    logic [5:0]  tx_wdata;
    logic        busy;
    logic [2:0]  seq;

    int          total = 0;
    int          bad = 0;
    int          pulses = 0;
    logic [5:0]  exp_q[$];
    logic [2:0]  exp_seq = 3'd0;
    logic        hold = 1'b0;
    logic [2:0]  ucnt;
    logic        prev_wreq = 1'b0;

    always #5 clk = ~clk;

    uart_tx_sched dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_ready (s1_ready),
        .tx_rdy   (tx_rdy),
        .tx_wreq  (tx_wreq),
        .tx_wdata (tx_wdata),
        .busy     (busy),
        .seq      (seq)
    );

    // uart_tx model: busy for 4 cycles after each write, rdy drops combinationally on wreq.
    always @(posedge clk or posedge rst) begin
        if (rst)          ucnt <= 3'd0;
        else if (tx_wreq) ucnt <= 3'd4;
        else if (ucnt != 0) ucnt <= ucnt - 3'd1;
    end
    assign tx_rdy = (ucnt == 3'd0) && !tx_wreq && !hold;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop one expected word per write pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_wreq) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_wreq: got word %0h expected no write", tx_wdata);
                end else begin
                    chk("tx_word", int'(tx_wdata), int'(exp_q.pop_front()));
                end
                if (prev_wreq) chk("wreq_back_to_back", 1, 0);
            end
            prev_wreq = tx_wreq;
        end else begin
            prev_wreq = 1'b0;
        end
    end

    task automatic push_frame(input logic ch, input logic [11:0] d);
        exp_q.push_back({2'b11, exp_seq, ch});
        exp_q.push_back(d[11:6]);
        exp_q.push_back(d[5:0]);
        exp_seq = exp_seq + 3'd1;
    endtask

    task automatic send(input int ch, input logic [11:0] d);
        bit done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (ch == 0) begin s0_valid = 1'b1; s0_data = d; end
            else         begin s1_valid = 1'b1; s1_data = d; end
            if ((ch == 0) ? s0_ready : s1_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            #2;
            if (!busy && exp_q.size() == 0) done = 1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_seq = 3'd0;
        chk("rst_wreq", tx_wreq, 0);
        chk("rst_wdata", tx_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq", seq, 0);
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_s0_ready", s0_ready, 1);
        chk("post_rst_s1_ready", s1_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int errs;
        int cnt;
        bit seen;
        logic [11:0] smp;

        // Single sample on channel 0
        do_reset();
        en = 1'b1;
        exp_q.push_back(6'h30);
        exp_q.push_back(6'h29);
        exp_q.push_back(6'h1C);
        exp_seq = 3'd1;
        send(0, 12'hA5C);
        wait_idle(500);
        chk("single_seq", seq, 1);
        chk("single_busy", busy, 0);

        // Simultaneous tie, then a second tie alternates
        do_reset();
        en = 1'b1;
        exp_q.push_back(6'h30); exp_q.push_back(6'h00); exp_q.push_back(6'h01);
        exp_q.push_back(6'h33); exp_q.push_back(6'h3F); exp_q.push_back(6'h3F);
        exp_seq = 3'd2;
        @(negedge clk);
        s0_valid = 1'b1; s0_data = 12'h001;
        s1_valid = 1'b1; s1_data = 12'hFFF;
        @(posedge clk); #1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        wait_idle(1000);
        chk("tie_seq", seq, 2);
        en = 1'b0;
        @(negedge clk);
        s0_valid = 1'b1; s0_data = 12'h041;
        s1_valid = 1'b1; s1_data = 12'h082;
        @(posedge clk); #1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        exp_q.push_back(6'h34); exp_q.push_back(6'h01); exp_q.push_back(6'h01);
        exp_q.push_back(6'h37); exp_q.push_back(6'h02); exp_q.push_back(6'h02);
        exp_seq = 3'd4;
        en = 1'b1;
        wait_idle(1000);
        chk("tie2_seq", seq, 4);

        // Nine frames: the ninth header carries seq 0 again
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            smp = 12'(i * 12'h123 + 12'h045);
            push_frame(1'b0, smp);
            send(0, smp);
        end
        wait_idle(3000);
        chk("wrap_seq", seq, 1);

        // tx_rdy held low while waiting on the header
        hold = 1'b1;
        p0 = pulses;
        push_frame(1'b0, 12'h5A5);
        send(0, 12'h5A5);
        repeat (3) @(negedge clk);
        chk("hold_busy", busy, 1);
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_wreq !== 1'b0 || tx_wdata !== 6'h32) errs++;
        end
        chk("hold_no_change", errs, 0);
        hold = 1'b0;
        wait_idle(500);
        chk("hold_pulse_count", pulses - p0, 3);

        // en dropped during word 2: frame completes, s1 stays buffered
        push_frame(1'b0, 12'h3C3);
        send(0, 12'h3C3);
        cnt = 0;
        for (int n = 0; n < 500 && cnt < 2; n++) begin
            @(negedge clk); #1;
            if (tx_wreq) cnt++;
        end
        chk("en_word2_seen", cnt, 2);
        en = 1'b0;
        send(1, 12'h9F0);
        wait_idle(500);
        repeat (20) @(negedge clk);
        #1;
        chk("en_off_busy", busy, 0);
        chk("en_off_s1_ready", s1_ready, 0);
        push_frame(1'b1, 12'h9F0);
        en = 1'b1;
        wait_idle(500);
        chk("en_on_s1_ready", s1_ready, 1);
        chk("en_on_seq", seq, 4);

        // Reset in GUARD after the header pulse
        exp_q.push_back({2'b11, exp_seq, 1'b0});
        send(0, 12'h777);
        seen = 0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk); #1;
            if (tx_wreq) seen = 1;
        end
        chk("rst_hdr_seen", seen, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_wreq", tx_wreq, 0);
        chk("midrst_wdata", tx_wdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_seq", seq, 0);
        chk("midrst_s0_ready", s0_ready, 0);
        exp_q.delete();
        exp_seq = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        p0 = pulses;
        repeat (40) @(negedge clk);
        #1;
        chk("midrst_no_wreq", pulses - p0, 0);
        chk("midrst_idle", busy, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
